// File: rtl/mux_scan.sv
// Registered N-channel, W-bit multiplexer with manual select and a dwell-timed
// auto-scanner that steps through the channels, with hold/pause support.
module mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 50_000_000
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [CHANNELS*WIDTH-1:0]                    din,
  input  logic                                         mode,
  input  logic [((CHANNELS <= 2) ? 1 : $clog2(CHANNELS))-1:0] sel,
  input  logic                                         hold,
  output logic [WIDTH-1:0]                             y,
  output logic [((CHANNELS <= 2) ? 1 : $clog2(CHANNELS))-1:0] ch,
  output logic                                         tick
);

  localparam int SEL_W = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS);
  localparam int CNT_W = (DWELL <= 1) ? 1 : $clog2(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    PAUSE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   ch_nxt;
  logic               tick_nxt;
  logic               sel_ok;
  logic [WIDTH-1:0]   y_p0;

  // Channel increment with wrap for non-power-of-two channel counts.
  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] c);
    if (int'(c) >= CHANNELS - 1) return '0;
    return c + 1'b1;
  endfunction

  assign sel_ok = (int'(sel) < CHANNELS);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ch_nxt    = ch;
    tick_nxt  = 1'b0;
    case (state)
      MANUAL: begin
        cnt_nxt = '0;
        if (mode) state_nxt = SCAN;
        else if (sel_ok) ch_nxt = sel;
      end
      SCAN: begin
        if (!mode) begin
          state_nxt = MANUAL;
          cnt_nxt   = '0;
        end else if (hold) begin
          // Pausing wins over an advance due in the same cycle.
          state_nxt = PAUSE;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt  = '0;
          ch_nxt   = wrap_inc(ch);
          tick_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PAUSE: begin
        if (!mode) begin
          state_nxt = MANUAL;
          cnt_nxt   = '0;
        end else if (!hold) begin
          state_nxt = SCAN;
        end
      end
      default: begin
        state_nxt = MANUAL;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    y_p0 = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (int'(ch) == k) y_p0 = din[k*WIDTH +: WIDTH];
    end
  end

  // Stage p0 -> registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MANUAL;
      cnt   <= '0;
      ch    <= '0;
      tick  <= 1'b0;
      y     <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ch    <= ch_nxt;
      tick  <= tick_nxt;
      y     <= y_p0;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// Directed bench for mux_scan: three instances cover 4-channel scan, 3-channel
// out-of-range select, and the DWELL=1 continuous-advance case.
module tb_mux_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instance a: 4 channels, dwell 3
  logic [15:0] din_a = 16'hDCBA;
  logic        mode_a = 1'b0, hold_a = 1'b0;
  logic [1:0]  sel_a = 2'd0;
  logic [3:0]  y_a;
  logic [1:0]  ch_a;
  logic        tick_a;

  // Instance b: 3 channels, dwell 3
  logic [11:0] din_b = 12'h987;
  logic        mode_b = 1'b0, hold_b = 1'b0;
  logic [1:0]  sel_b = 2'd0;
  logic [3:0]  y_b;
  logic [1:0]  ch_b;
  logic        tick_b;

  // Instance c: 3 channels, dwell 1
  logic [11:0] din_c = 12'h654;
  logic        mode_c = 1'b0, hold_c = 1'b0;
  logic [1:0]  sel_c = 2'd0;
  logic [3:0]  y_c;
  logic [1:0]  ch_c;
  logic        tick_c;

  mux_scan #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .mode(mode_a), .sel(sel_a),
    .hold(hold_a), .y(y_a), .ch(ch_a), .tick(tick_a));

  mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(3)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .mode(mode_b), .sel(sel_b),
    .hold(hold_b), .y(y_b), .ch(ch_b), .tick(tick_b));

  mux_scan #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) dut_c (
    .clk(clk), .rst(rst), .din(din_c), .mode(mode_c), .sel(sel_c),
    .hold(hold_c), .y(y_c), .ch(ch_c), .tick(tick_c));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset
    step(2);
    chk("rst_y", 32'(y_a), 32'h0);
    chk("rst_ch", 32'(ch_a), 32'h0);
    chk("rst_tick", 32'(tick_a), 32'h0);

    // Manual select
    sel_a = 2'd2; sel_b = 2'd1; sel_c = 2'd0; rst = 1'b0;
    step(1);
    chk("man_ch", 32'(ch_a), 32'h2);
    chk("man_tick", 32'(tick_a), 32'h0);
    chk("man_y_early", 32'(y_a), 32'hA);
    step(1);
    chk("man_y", 32'(y_a), 32'hC);
    chk("man_b_ch", 32'(ch_b), 32'h1);
    chk("man_b_y", 32'(y_b), 32'h8);

    // Out-of-range select on 3-channel instance
    sel_b = 2'd3;
    step(2);
    chk("oor_ch", 32'(ch_b), 32'h1);
    chk("oor_y", 32'(y_b), 32'h8);
    chk("oor_tick", 32'(tick_b), 32'h0);

    // Auto scan from ch=2 with wrap
    mode_a = 1'b1;
    step(1);
    chk("scan_entry_ch", 32'(ch_a), 32'h2);
    step(2);
    chk("scan_pre_ch", 32'(ch_a), 32'h2);
    chk("scan_pre_tick", 32'(tick_a), 32'h0);
    step(1);
    chk("scan1_ch", 32'(ch_a), 32'h3);
    chk("scan1_tick", 32'(tick_a), 32'h1);
    chk("scan1_y_old", 32'(y_a), 32'hC);
    step(1);
    chk("scan1_y", 32'(y_a), 32'hD);
    chk("scan1_tick_off", 32'(tick_a), 32'h0);
    step(2);
    chk("scan2_ch", 32'(ch_a), 32'h0);
    chk("scan2_tick", 32'(tick_a), 32'h1);
    step(1);
    chk("scan2_y", 32'(y_a), 32'hA);
    step(2);
    chk("scan3_ch", 32'(ch_a), 32'h1);
    chk("scan3_tick", 32'(tick_a), 32'h1);
    step(1);
    chk("scan3_y", 32'(y_a), 32'hB);

    // cnt=1 now; hold for 5 cycles
    hold_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("pause_ch", 32'(ch_a), 32'h1);
      chk("pause_tick", 32'(tick_a), 32'h0);
    end
    hold_a = 1'b0;
    step(1);
    chk("resume0_ch", 32'(ch_a), 32'h1);
    step(1);
    chk("resume1_ch", 32'(ch_a), 32'h1);
    chk("resume1_tick", 32'(tick_a), 32'h0);
    step(1);
    chk("resume2_ch", 32'(ch_a), 32'h2);
    chk("resume2_tick", 32'(tick_a), 32'h1);

    // Hold rising at cnt=DWELL-1 blocks the advance
    step(2);
    hold_a = 1'b1;
    step(1);
    chk("holdlast_ch", 32'(ch_a), 32'h2);
    chk("holdlast_tick", 32'(tick_a), 32'h0);
    hold_a = 1'b0;
    step(1);
    chk("holdlast_rel_ch", 32'(ch_a), 32'h2);
    step(1);
    chk("holdlast_adv_ch", 32'(ch_a), 32'h3);
    chk("holdlast_adv_tick", 32'(tick_a), 32'h1);

    // mode=0 with hold=1 returns to manual
    mode_a = 1'b0; hold_a = 1'b1; sel_a = 2'd1;
    step(1);
    chk("prio_exit_ch", 32'(ch_a), 32'h3);
    step(1);
    chk("prio_man_ch", 32'(ch_a), 32'h1);
    chk("prio_man_tick", 32'(tick_a), 32'h0);

    // Reset mid-scan at cnt=2
    mode_a = 1'b1; hold_a = 1'b0;
    step(3);
    chk("pre_rst_ch", 32'(ch_a), 32'h1);
    rst = 1'b1;
    step(1);
    chk("midrst_ch", 32'(ch_a), 32'h0);
    chk("midrst_y", 32'(y_a), 32'h0);
    chk("midrst_tick", 32'(tick_a), 32'h0);
    step(1);
    chk("midrst_hold_ch", 32'(ch_a), 32'h0);

    // DWELL=1, 3 channels: advance every cycle
    rst = 1'b0; mode_a = 1'b0; mode_c = 1'b1;
    step(1);
    chk("d1_k0_ch", 32'(ch_c), 32'h0);
    chk("d1_k0_tick", 32'(tick_c), 32'h0);
    step(1);
    chk("d1_k1_ch", 32'(ch_c), 32'h1);
    chk("d1_k1_tick", 32'(tick_c), 32'h1);
    step(1);
    chk("d1_k2_ch", 32'(ch_c), 32'h2);
    chk("d1_k2_tick", 32'(tick_c), 32'h1);
    chk("d1_k2_y", 32'(y_c), 32'h5);
    step(1);
    chk("d1_k3_ch", 32'(ch_c), 32'h0);
    chk("d1_k3_tick", 32'(tick_c), 32'h1);
    chk("d1_k3_y", 32'(y_c), 32'h6);
    step(1);
    chk("d1_k4_ch", 32'(ch_c), 32'h1);
    chk("d1_k4_tick", 32'(tick_c), 32'h1);
    chk("d1_k4_y", 32'(y_c), 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
